// File: rtl/seq1010_pkg.sv
// Shared types and constants for the 1010-framed serial transmitter.
// Optional feature macro: SEQ1010_TX_PARITY_EN (appends an even-parity bit).
package seq1010_pkg;

    // Frame phases; PARITY is only reachable when the parity bit is enabled.
    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } tx_state_e;

    localparam logic [3:0] SYNC_PATTERN = 4'b1010;
    localparam int         SYNC_LEN     = 4;

    // Sync bit for position idx (0 = first on the line); the pattern goes out MSB first.
    function automatic logic sync_bit(input logic [1:0] idx);
        logic [1:0] pos;
        pos = ~idx;
        return SYNC_PATTERN[pos];
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq1010_frame_tx_shift_reg.sv
// Payload shifter: parallel load, MSB-first left shift; the MSB is the next payload bit.
module tx_shift_reg
    import seq1010_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] d,
    output logic              msb
);

    logic [DATA_W-1:0] sr;

    // Load wins over shift; the two never coincide in normal operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   sr <= '0;
        else if (load)  sr <= d;
        else if (shift) sr <= sr << 1;
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/seq1010_frame_tx.sv
// Serial frame transmitter: sync 1010, then payload MSB first, then idle gap.
// Optional feature macro: SEQ1010_TX_PARITY_EN adds one even-parity bit after
// the payload and moves `done` onto it.
// Every output is registered from next-state values, so the bit shown on `out`
// always belongs to the state currently held in `state`.
module seq1010_frame_tx
    import seq1010_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int GAP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              out_valid,
    output logic              done
);

    // Wide enough for the payload count; widened if the sync or gap count needs more.
    localparam int CNT_W = max3($clog2(DATA_W + 1), $clog2(GAP_LEN + 1), $clog2(SYNC_LEN + 1));
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    // State after the last frame bit: the gap, or IDLE when no gap is configured.
    localparam tx_state_e POST_FRAME = (GAP_LEN > 0) ? GAP : IDLE;

    tx_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             out_n, ov_n, done_n;
    logic             load, shift, sr_msb;

`ifdef SEQ1010_TX_PARITY_EN
    logic par_q;

    // Even parity of the accepted word, captured at the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  par_q <= 1'b0;
        else if (load) par_q <= ^in_data;
    end
`endif

    tx_shift_reg #(.DATA_W(DATA_W)) u_sr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .shift   (shift),
        .d       (in_data),
        .msb     (sr_msb)
    );

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            out       <= out_n;
            out_valid <= ov_n;
            done      <= done_n;
            in_ready  <= (state_n == IDLE);
        end
    end

    // Next state / counter, then the line value that the next state puts on `out`.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        out_n   = 1'b0;
        ov_n    = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                    load    = 1'b1;
                end
            end
            SYNC: begin
                if (cnt == SYNC_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == DATA_LAST) begin
`ifdef SEQ1010_TX_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = POST_FRAME;
`endif
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef SEQ1010_TX_PARITY_EN
            PARITY: begin
                state_n = POST_FRAME;
                cnt_n   = '0;
            end
`endif
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        case (state_n)
            SYNC: begin
                ov_n  = 1'b1;
                out_n = sync_bit(cnt_n[1:0]);
            end
            DATA: begin
                // Present the current MSB and advance so the next bit is ready.
                ov_n  = 1'b1;
                out_n = sr_msb;
                shift = 1'b1;
`ifndef SEQ1010_TX_PARITY_EN
                done_n = (cnt_n == DATA_LAST);
`endif
            end
`ifdef SEQ1010_TX_PARITY_EN
            PARITY: begin
                ov_n   = 1'b1;
                out_n  = par_q;
                done_n = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
